// File: rtl/alu_issue_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_issue_arbiter_if
// Bundles the two request channels, the ALU issue/complete signals and the
// shared response channel of alu_issue_arbiter.
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where both valid and ready are high. The source holds valid and its
// payload stable until that edge. Ready may depend combinationally on valid.
//
// Modports:
//   master : the arbiter's view. It drives readies, ALU start/operands and
//            the response channel.
//   slave  : the environment's view. It holds the requesters, the ALU and
//            the response consumer.
// ---------------------------------------------------------------------------
interface alu_issue_arbiter_if #(
   parameter int DATA_W = 8
) ();
   // request port 0 (core control sequencer)
   logic              req0_valid;
   logic              req0_ready;
   logic [2:0]        req0_opcode;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   // request port 1 (AXI-Lite host command path)
   logic              req1_valid;
   logic              req1_ready;
   logic [2:0]        req1_opcode;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   // ALU issue / completion
   logic              alu_en;
   logic [2:0]        alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic              alu_done;
   logic [DATA_W-1:0] alu_result;
   logic              alu_flag;
   // shared response channel
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_flag;
   logic              rsp_err;
   logic              rsp_we;

   modport master (
      input  req0_valid, req0_opcode, req0_a, req0_b,
      input  req1_valid, req1_opcode, req1_a, req1_b,
      input  alu_done, alu_result, alu_flag,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output alu_en, alu_op, alu_a, alu_b,
      output rsp_valid, rsp_id, rsp_data, rsp_flag, rsp_err, rsp_we
   );

   modport slave (
      output req0_valid, req0_opcode, req0_a, req0_b,
      output req1_valid, req1_opcode, req1_a, req1_b,
      output alu_done, alu_result, alu_flag,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_en, alu_op, alu_a, alu_b,
      input  rsp_valid, rsp_id, rsp_data, rsp_flag, rsp_err, rsp_we
   );
endinterface

// File: rtl/alu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// alu_issue_arbiter
// Shares one ALU between two requesters. A request is accepted in IDLE
// (round-robin on a tie), issued to the ALU with a one-cycle alu_en pulse,
// awaited with a timeout, and answered on a shared response channel tagged
// with the requester id. Opcodes: 000 ADD, 001 RSHIFT, 010 POPCOUNT,
// 011 COMPARE, 1xx illegal. Only ADD/RSHIFT/POPCOUNT without error write back.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   bus        alu_issue_arbiter_if.master (requests, ALU, response)
//   state_dbg  current FSM state: IDLE=00 ISSUE=01 WAIT=10 RESP=11
// ---------------------------------------------------------------------------
module alu_issue_arbiter #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_issue_arbiter_if.master   bus,
   output logic [1:0]            state_dbg
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10,
      S_RESP  = 2'b11
   } state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              id_q, id_d;
   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              flag_q, flag_d;
   logic              err_q, err_d;
   logic [TW-1:0]     timer_q, timer_d;

   logic              grant_c;
   logic              ready0_c, ready1_c, alu_en_c, rsp_valid_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;   // port 0 wins the first tie
         id_q         <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         data_q       <= '0;
         flag_q       <= 1'b0;
         err_q        <= 1'b0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         data_q       <= data_d;
         flag_q       <= flag_d;
         err_q        <= err_d;
         timer_q      <= timer_d;
      end
   end

   // A lone valid port wins; on a tie the port not granted last time wins.
   always_comb begin
      grant_c = bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
         grant_c = ~last_grant_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      data_d       = data_q;
      flag_d       = flag_q;
      err_d        = err_q;
      timer_d      = timer_q;
      ready0_c     = 1'b0;
      ready1_c     = 1'b0;
      alu_en_c     = 1'b0;
      rsp_valid_c  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               ready0_c     = ~grant_c;
               ready1_c     = grant_c;
               id_d         = grant_c;
               last_grant_d = grant_c;
               op_d         = grant_c ? bus.req1_opcode : bus.req0_opcode;
               a_d          = grant_c ? bus.req1_a      : bus.req0_a;
               b_d          = grant_c ? bus.req1_b      : bus.req0_b;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!op_q[2]) begin
               alu_en_c = 1'b1;
               timer_d  = '0;
               state_d  = S_WAIT;
            end else begin
               // illegal opcode: never reaches the ALU
               err_d   = 1'b1;
               data_d  = '0;
               flag_d  = 1'b0;
               state_d = S_RESP;
            end
         end
         S_WAIT: begin
            timer_d = timer_q + 1'b1;
            // done is checked first so a done on the last allowed cycle wins
            if (bus.alu_done) begin
               data_d  = bus.alu_result;
               flag_d  = bus.alu_flag;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               data_d  = '0;
               flag_d  = 1'b0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid_c = 1'b1;
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic in_idle, in_resp;
   assign in_idle = (state_q == S_IDLE);
   assign in_resp = (state_q == S_RESP);

   assign bus.req0_ready = ready0_c;
   assign bus.req1_ready = ready1_c;
   assign bus.alu_en     = alu_en_c;
   assign bus.alu_op     = in_idle ? 3'b000 : op_q;
   assign bus.alu_a      = in_idle ? '0 : a_q;
   assign bus.alu_b      = in_idle ? '0 : b_q;
   assign bus.rsp_valid  = rsp_valid_c;
   assign bus.rsp_id     = in_resp & id_q;
   assign bus.rsp_data   = in_resp ? data_q : '0;
   assign bus.rsp_flag   = in_resp & flag_q;
   assign bus.rsp_err    = in_resp & err_q;
   // COMPARE (011), illegal opcodes (1xx) and errors never write back
   assign bus.rsp_we     = in_resp & ~op_q[2] & (op_q[1:0] != 2'b11) & ~err_q;
   assign state_dbg      = state_q;

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single ALU execution resource between two requesters: port 0 (core control sequencer) and port 1 (AXI-Lite host command path). Requests are accepted with a valid/ready handshake, arbitrated round-robin, and issued as a one-cycle `alu_en` start pulse. The block waits for `alu_done`, with a timeout, and returns the result on a shared response channel tagged with the requester ID. Writeback qualification follows the core ISA: ADD, RSHIFT and POPCOUNT write back; COMPARE does not.

## Interface
- `DATA_W`, 8: operand and result width.
- `TIMEOUT`, 15: maximum WAIT cycles before an error response; must be ≥ 2.
- `clk`  in  1  clock. One clock domain; everything is sampled on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req0_valid`, `req1_valid`  in  1  request valid, per port.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle, per port.
- `req0_opcode`, `req1_opcode`  in  3  opcodes: 000 ADD, 001 RSHIFT, 010 POPCOUNT, 011 COMPARE, 1xx illegal.
- `req0_a`/`req0_b`, `req1_a`/`req1_b`  in  DATA_W  operands.
- `alu_en`  out  1  one-cycle start pulse to the ALU.
- `alu_op`  out  3  latched opcode.
- `alu_a`/`alu_b`  out  DATA_W  latched operands.
- `alu_done`  in  1  ALU result valid.
- `alu_result`  in  DATA_W  ALU result.
- `alu_flag`  in  1  compare/zero flag.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accepted.
- `rsp_id`  out  1  requester index of the response.
- `rsp_data`  out  DATA_W  result.
- `rsp_flag`  out  1  captured `alu_flag`.
- `rsp_err`  out  1  timeout or illegal opcode.
- `rsp_we`  out  1  writeback permitted.
- `state_dbg`  out  2  current state.

## Operation
- States and `state_dbg` encodings: IDLE=00, ISSUE=01, WAIT=10, RESP=11.
- **IDLE:**
  - If any `reqN_valid` is high, pick a grant `g`: a single valid port wins; if both are valid, `g = ~last_grant`.
  - `req<g>_ready` is high combinationally this cycle; the other port's ready is low.
  - On the handshake, latch opcode, a, b and `g`, set `last_grant <= g`, and go to ISSUE.
  - If no request is valid, stay in IDLE.
- **ISSUE (1 cycle):**
  - Opcode 0xx: `alu_en = 1`, timer cleared, go to WAIT.
  - Opcode 1xx: `alu_en` stays 0. Set `rsp_err = 1`, `rsp_data = 0`, `rsp_flag = 0`, and go to RESP.
- **WAIT:**
  - Timer increments every cycle.
  - If `alu_done`: capture `alu_result` and `alu_flag`, set `rsp_err = 0`, go to RESP.
  - Otherwise, if the timer reaches `TIMEOUT`: `rsp_data = 0`, `rsp_flag = 0`, `rsp_err = 1`, go to RESP.
  - `alu_done` in the same cycle as the timeout: done wins, and no error is reported.
- **RESP:**
  - `rsp_valid = 1`, with data, flag, err and id held stable until `rsp_valid && rsp_ready`, then go to IDLE.
  - `rsp_we = 1` only if opcode ∈ {000, 001, 010} and `rsp_err = 0`.
  - COMPARE, errors and illegal opcodes give `rsp_we = 0`.
- `alu_op`, `alu_a` and `alu_b` hold the latched values from ISSUE through RESP; they are 0 in IDLE.
- Every `reqN_ready` is 0 outside IDLE, so at most one operation is in flight.
- `alu_done` is ignored outside WAIT; a stray done in IDLE, ISSUE or RESP has no effect.
- Requesters must hold valid and payload stable until ready. The arbiter does not depend on this, because it samples only on the handshake cycle.

## Timing
- Reset, sampled on an edge with `rst = 1`:
  - state IDLE;
  - `last_grant = 1`, so port 0 wins the first tie;
  - timer 0;
  - all outputs 0, including `alu_en`, both readies, `rsp_*` and `state_dbg = 00`.
- Reset mid-operation abandons the transaction: no response is emitted, and `alu_en`/`rsp_valid` are 0 from the next cycle.
- Minimum latency, with request accepted at cycle T:
  - `alu_en` at T+1;
  - earliest `alu_done` at T+2;
  - `rsp_valid` at T+3;
  - if `rsp_ready` is high at T+3, IDLE at T+4 and the next accept possible at T+4.
- Illegal opcode: accept at T, ISSUE at T+1, `rsp_valid` at T+2.
- Timeout: with no done, `rsp_valid` with `rsp_err` rises TIMEOUT+1 cycles after `alu_en`.
- Response backpressure: RESP holds indefinitely, and no new request is accepted meanwhile.

## Test plan
- **Single ADD on port 0:** a=8'h05, b=8'h03 with the ALU model returning 8'h08 one cycle after `alu_en` → `alu_en` at T+1; `rsp_valid` at T+3 with id=0, data=8'h08, we=1, err=0.
- **Contention:** both ports valid continuously for 4 ops → grants 0,1,0,1; each `reqN_ready` asserted exactly once per op; `rsp_id` sequence 0,1,0,1.
- **COMPARE on port 1:** ALU returns flag=1 → `rsp_flag = 1`, `rsp_we = 0`, `rsp_err = 0`.
- **Timeout:** ALU never asserts done, TIMEOUT=15 → `rsp_err = 1`, data=0, we=0, `rsp_valid` 16 cycles after `alu_en`. Repeat with done on the 15th WAIT cycle → err=0.
- **Illegal opcode 3'b101:** `alu_en` never pulses; `rsp_err = 1` at T+2. Also: `rsp_ready` held low for 5 cycles → response fields stable and both readies 0 throughout.
- **Reset in WAIT:** `rst` pulsed for 1 cycle → all outputs 0 and `state_dbg = 00` next cycle; no response; a later tie grants port 0.
